// File: rtl/jump_pkg.sv
// Shared types and default constants for the jump physics block.
// Default physics: launch speed 6, gravity 1 per tick, terminal fall
// speed 8, floor at y=368 (y grows downward).
package jump_pkg;

   typedef enum logic [1:0] {
      GROUND = 2'd0,
      RISE   = 2'd1,
      FALL   = 2'd2
   } jump_state_t;

   localparam int JP_W      = 10;
   localparam int JP_N_PLAT = 2;
   localparam int JP_DIV    = 3;
   localparam int JP_V0     = 6;
   localparam int JP_G      = 1;
   localparam int JP_VMAX   = 8;
   localparam int JP_GND_Y  = 368;

endpackage

// File: rtl/jump_physics_if.sv
// Signal bundle between the game logic (master) and the jump physics
// block (slave).
//
// Handshake: step_valid is a one-cycle valid with no ready. The consumer
// must add dy to its sprite y in the same cycle step_valid is high; dy is
// zero whenever step_valid is low. landed is a one-cycle pulse that only
// ever coincides with step_valid. state_dbg/vel_dbg mirror internal state.
interface jump_physics_if #(
   parameter int W      = jump_pkg::JP_W,
   parameter int N_PLAT = jump_pkg::JP_N_PLAT
);
   import jump_pkg::*;

   logic                           jump_req;
   logic [W-1:0]                   sprite_x;
   logic [W-1:0]                   sprite_y;
   logic [N_PLAT-1:0][W-1:0]       plat_x0;
   logic [N_PLAT-1:0][W-1:0]       plat_x1;
   logic [N_PLAT-1:0][W-1:0]       plat_y;
   logic signed [W-1:0]            dy;
   logic                           step_valid;
   logic                           on_gnd;
   logic                           landed;
   jump_state_t                    state_dbg;
   logic signed [W-1:0]            vel_dbg;

   modport master (
      output jump_req, sprite_x, sprite_y, plat_x0, plat_x1, plat_y,
      input  dy, step_valid, on_gnd, landed, state_dbg, vel_dbg
   );

   modport slave (
      input  jump_req, sprite_x, sprite_y, plat_x0, plat_x1, plat_y,
      output dy, step_valid, on_gnd, landed, state_dbg, vel_dbg
   );

endinterface

// File: rtl/jump_surface_sel.sv
// Combinational surface logic: decides whether the sprite is standing on
// something, and which surface (floor or in-span platform) it would cross
// while moving down by vel_next. The smallest crossed y wins; on equal y
// the floor, then the lowest platform index, is kept.
module jump_surface_sel #(
   parameter int W      = 10,
   parameter int N_PLAT = 2,
   parameter int GND_Y  = 368
) (
   input  logic [W-1:0]             sprite_x,
   input  logic [W-1:0]             sprite_y,
   input  logic [N_PLAT-1:0][W-1:0] plat_x0,
   input  logic [N_PLAT-1:0][W-1:0] plat_x1,
   input  logic [N_PLAT-1:0][W-1:0] plat_y,
   input  logic signed [W-1:0]      vel_next,
   output logic                     support,
   output logic                     land_hit,
   output logic [W-1:0]             land_s
);

   localparam logic [W-1:0] GND_U = W'(GND_Y);

   logic signed [W+1:0] lo_s;
   logic signed [W+1:0] hi_s;
   logic [N_PLAT-1:0]   in_span;

   // Surface s is crossed when sprite_y <= s <= sprite_y + vel_next
   function automatic logic crossed(input logic [W-1:0] s,
                                    input logic signed [W+1:0] lo,
                                    input logic signed [W+1:0] hi);
      logic signed [W+1:0] s_s;
      s_s = $signed({2'b00, s});
      return (s_s >= lo) && (s_s <= hi);
   endfunction

   // Support test and smallest-crossed-surface search
   always_comb begin
      lo_s     = $signed({2'b00, sprite_y});
      hi_s     = lo_s + $signed({{2{vel_next[W-1]}}, vel_next});
      in_span  = '0;
      support  = (sprite_y == GND_U);
      land_hit = crossed(GND_U, lo_s, hi_s);
      land_s   = land_hit ? GND_U : '0;
      for (int i = 0; i < N_PLAT; i++) begin
         in_span[i] = (plat_x0[i] <= sprite_x) && (sprite_x <= plat_x1[i]);
         if (in_span[i] && (sprite_y == plat_y[i])) begin
            support = 1'b1;
         end
         if (in_span[i] && crossed(plat_y[i], lo_s, hi_s) &&
             (!land_hit || (plat_y[i] < land_s))) begin
            land_hit = 1'b1;
            land_s   = plat_y[i];
         end
      end
   end

endmodule

// File: rtl/jump_physics.sv
// Jump physics for a platformer sprite. Every DIV frame_clk cycles a
// physics tick advances a GROUND/RISE/FALL machine and emits one y step
// (dy) one cycle later. Optional feature: define JUMP_DOUBLE_EN to allow
// one extra jump while airborne.
module jump_physics
   import jump_pkg::*;
#(
   parameter int W      = JP_W,
   parameter int N_PLAT = JP_N_PLAT,
   parameter int DIV    = JP_DIV,
   parameter int V0     = JP_V0,
   parameter int G      = JP_G,
   parameter int VMAX   = JP_VMAX,
   parameter int GND_Y  = JP_GND_Y
) (
   input  logic          frame_clk,
   input  logic          Reset_n,
   jump_physics_if.slave bus
);

   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0]       DIV_LAST = DW'(DIV - 1);
   localparam logic signed [W-1:0] V0_S     = W'(V0);
   localparam logic signed [W-1:0] G_S      = W'(G);
   localparam logic signed [W-1:0] VMAX_S   = W'(VMAX);
   localparam logic [W-1:0]        GND_U    = W'(GND_Y);

   logic [DW-1:0]       div_q, div_d;
   logic                tick;
   logic                jump_prev_q, jump_prev_d;
   logic                pending_q, pending_d;
   logic                jump_edge, jump_now, dbl_ok;
   jump_state_t         state_q, state_d;
   logic signed [W-1:0] vel_q, vel_d;
   logic signed [W-1:0] vel_inc, vel_fall;
   logic signed [W-1:0] dy_q, dy_d;
   logic                step_q, step_d;
   logic                landed_q, landed_d;
   logic                air_q, air_d;
   logic                support, land_hit;
   logic [W-1:0]        land_s;

   // Tick divider: counts 0..DIV-1, tick on the last count
   always_comb begin
      tick  = (div_q == DIV_LAST);
      div_d = tick ? '0 : div_q + 1'b1;
   end

   // Rising-edge detect on jump_req; the edge is held until a tick uses it
   always_comb begin
      jump_edge   = bus.jump_req & ~jump_prev_q;
      jump_prev_d = bus.jump_req;
      jump_now    = pending_q | jump_edge;
   end

`ifdef JUMP_DOUBLE_EN
   assign dbl_ok = jump_now & ~air_q;
`else
   assign dbl_ok = 1'b0;
`endif

   // Velocity candidates: plain gravity and gravity clamped to terminal speed
   always_comb begin
      vel_inc  = vel_q + G_S;
      vel_fall = (vel_inc > VMAX_S) ? VMAX_S : vel_inc;
   end

   jump_surface_sel #(
      .W      (W),
      .N_PLAT (N_PLAT),
      .GND_Y  (GND_Y)
   ) u_surface_sel (
      .sprite_x (bus.sprite_x),
      .sprite_y (bus.sprite_y),
      .plat_x0  (bus.plat_x0),
      .plat_x1  (bus.plat_x1),
      .plat_y   (bus.plat_y),
      .vel_next (vel_fall),
      .support  (support),
      .land_hit (land_hit),
      .land_s   (land_s)
   );

   // Next-state, velocity and step computation, evaluated only on tick
   always_comb begin
      state_d   = state_q;
      vel_d     = vel_q;
      dy_d      = '0;
      step_d    = tick;
      landed_d  = 1'b0;
      air_d     = air_q;
      pending_d = jump_now;
      if (tick) begin
         pending_d = 1'b0;
         if (bus.sprite_y > GND_U) begin
            // Sunk below the floor: snap back up regardless of state
            state_d = GROUND;
            vel_d   = '0;
            dy_d    = GND_U - bus.sprite_y;
         end else begin
            case (state_q)
               GROUND: begin
                  if (jump_now) begin
                     state_d = RISE;
                     vel_d   = -V0_S;
                     dy_d    = -V0_S;
                  end else if (!support) begin
                     state_d = FALL;
                     vel_d   = '0;
                  end
               end
               RISE: begin
                  if (dbl_ok) begin
                     vel_d = -V0_S;
                     dy_d  = -V0_S;
                     air_d = 1'b1;
                  end else begin
                     vel_d = vel_inc;
                     dy_d  = vel_inc;
                     if (!vel_inc[W-1]) state_d = FALL;
                  end
               end
               FALL: begin
                  if (dbl_ok) begin
                     state_d = RISE;
                     vel_d   = -V0_S;
                     dy_d    = -V0_S;
                     air_d   = 1'b1;
                  end else if (land_hit) begin
                     state_d  = GROUND;
                     vel_d    = '0;
                     dy_d     = land_s - bus.sprite_y;
                     landed_d = 1'b1;
                  end else begin
                     vel_d = vel_fall;
                     dy_d  = vel_fall;
                  end
               end
               default: begin
                  state_d = GROUND;
                  vel_d   = '0;
               end
            endcase
         end
         if (state_d == GROUND) air_d = 1'b0;
      end
   end

   // State and output registers
   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         div_q       <= '0;
         jump_prev_q <= 1'b0;
         pending_q   <= 1'b0;
         state_q     <= GROUND;
         vel_q       <= '0;
         dy_q        <= '0;
         step_q      <= 1'b0;
         landed_q    <= 1'b0;
         air_q       <= 1'b0;
      end else begin
         div_q       <= div_d;
         jump_prev_q <= jump_prev_d;
         pending_q   <= pending_d;
         state_q     <= state_d;
         vel_q       <= vel_d;
         dy_q        <= dy_d;
         step_q      <= step_d;
         landed_q    <= landed_d;
         air_q       <= air_d;
      end
   end

   assign bus.dy         = dy_q;
   assign bus.step_valid = step_q;
   assign bus.landed     = landed_q;
   assign bus.on_gnd     = (state_q == GROUND);
   assign bus.state_dbg  = state_q;
   assign bus.vel_dbg    = vel_q;

endmodule

// File: doc/jump_physics.md
JUMP_PHYSICS -- requirements
Module: jump_physics

Interface
REQ-001 SHALL have parameter W, default 10, meaning coordinate/velocity width in bits.
REQ-002 SHALL have parameter N_PLAT, default 2, meaning number of platforms.
REQ-003 SHALL have parameter DIV, default 3, meaning frame_clk cycles per physics tick (DIV>=1).
REQ-004 SHALL have parameters V0=6 (launch speed), G=1 (gravity per tick), VMAX=8 (terminal fall speed) and GND_Y=368 (floor y).
REQ-005 SHALL have port frame_clk, input, 1, the only clock; all logic on its rising edge.
REQ-006 SHALL have port Reset_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port jump_req, input, 1, level jump key; only a 0->1 edge counts.
REQ-008 SHALL have ports sprite_x and sprite_y, input, W each, sprite foot position.
REQ-009 SHALL have ports plat_x0, plat_x1 and plat_y, input, N_PLAT x W each, inclusive platform span and top y.
REQ-010 SHALL have port dy, output, W, signed two's-complement y step (positive = down).
REQ-011 SHALL have ports step_valid (1-cycle pulse when dy is to be applied), on_gnd and landed (1-cycle pulse on touchdown), output, 1 each.

Function
REQ-012 SHALL count 0..DIV-1 on frame_clk and raise tick when count==DIV-1; all state/velocity updates happen only on tick.
REQ-013 SHALL latch a jump_req rising edge in a pending flag held until the next tick consumes it.
REQ-014 SHALL register dy, step_valid and landed one frame_clk after tick; step_valid high exactly once per tick, and dy=0 whenever step_valid=0.
REQ-015 SHALL define support as sprite_y==GND_Y, or, for some i, sprite_y==plat_y[i] with plat_x0[i]<=sprite_x<=plat_x1[i].
REQ-016 SHALL implement states GROUND, RISE, FALL with signed W-bit velocity vel.
REQ-017 GROUND: on_gnd=1; pending jump -> RISE, vel=-V0, dy=-V0; otherwise no support -> FALL, vel=0, dy=0; else dy=0.
REQ-018 RISE: vel_next=vel+G, dy=vel_next; if vel_next>=0 -> FALL.
REQ-019 FALL: vel_next=min(vel+G,VMAX), dy=vel_next, unless landing applies.
REQ-020 Landing SHALL occur in FALL when some surface S (floor or in-span platform) has sprite_y<=S<=sprite_y+vel_next: dy=S-sprite_y, vel=0, state GROUND, landed pulses.
REQ-021 SHALL choose the smallest S when several surfaces are crossed; on equal S the lowest index wins.
REQ-022 SHALL, in any state, when sprite_y>GND_Y, output dy=GND_Y-sprite_y, vel=0, state GROUND; this overrides REQ-017 to REQ-020.
REQ-023 SHALL ignore and clear a pending jump in RISE/FALL, unless REQ-029 applies.
REQ-024 SHALL deassert on_gnd in RISE and FALL.

Reset
REQ-025 SHALL, while Reset_n=0, force state GROUND, vel=0, divider=0, pending=0, dy=0, step_valid=0, landed=0 and on_gnd=1, including mid-air.
REQ-026 SHALL deliver the first tick DIV cycles after Reset_n rises.

Configuration
REQ-027 SHALL provide macro JUMP_DOUBLE_EN.
REQ-028 SHALL, without JUMP_DOUBLE_EN, permit only ground jumps.
REQ-029 SHALL, with JUMP_DOUBLE_EN, let a pending jump in RISE/FALL with air_used=0 set vel=-V0, dy=-V0, state RISE, air_used=1; air_used clears on entering GROUND or on reset.

Structure
REQ-030 SHALL place typedef jump_state_t and the default constants (V0, G, VMAX, GND_Y) in package jump_pkg.
REQ-031 SHALL place support/landing surface selection in combinational sub-module jump_surface_sel, parametrised by W and N_PLAT.

Verification
REQ-032 SHALL verify a full jump: defaults, y=368, x=100, jump edge, bench integrates dy -> dy -6,-5,-4,-3,-2,-1,0,1,2,3,4,5,6; landed with y=368; one step per 3 cycles.
REQ-033 SHALL verify a platform landing: plat0 296..345 y=331, x=320, FALL vel=3, y=328 -> dy=3, landed=1, on_gnd=1 next.
REQ-034 SHALL verify walking off: GROUND y=331, x set to 350 -> next tick FALL, dy=0, then dy=1.
REQ-035 SHALL verify below-floor correction: y=372 in any state -> dy=-4, GROUND.
REQ-036 SHALL verify double jump: edge during FALL -> dy=-6 with JUMP_DOUBLE_EN, dy unchanged without; a third edge is ignored.
REQ-037 SHALL verify reset mid-air: Reset_n low during RISE -> dy=0, on_gnd=1, step_valid=0 immediately.
